uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester/transmitter bundle shared by the UART TX arbiter and its environment.
// Latency: none, this is plain wiring.
// Backpressure: a requester holds req and req_data steady until its ack, and tx_done paces the frames.
// Ports: req/req_data are the per-requester byte offers. grant/ack are ownership and capture strobes.
//        tx_start/tx_data/tx_done form the UART transmitter handshake. busy/err report status.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   ack;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_done;
  logic               busy;
  logic               err;

  // Environment side: requesters plus the UART transmitter.
  modport master (
    output req, req_data, tx_done,
    input  grant, ack, tx_start, tx_data, busy, err
  );

  // Arbiter side.
  modport slave (
    input  req, req_data, tx_done,
    output grant, ack, tx_start, tx_data, busy, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds bytes from N_REQ requesters into one UART transmitter.
// Latency: from req rising in IDLE to tx_start is 3 cycles. Within a burst, tx_done leads to tx_start after one LOAD cycle.
// Backpressure: a requester keeps its byte until ack. Each frame waits for tx_done or aborts on timeout.
// Ports: clk, and rst (asynchronous, active-high). bus is the slave modport of uart_tx_arbiter_if,
//        which carries req/req_data in, grant/ack out, tx_start/tx_data out, tx_done in, and busy/err out.
module uart_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 65535
) (
  input logic               clk,
  input logic               rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ARB, LOAD, WAIT} state_t;

  state_t          state;
  logic [IW-1:0]   last;       // most recent owner; the search starts just after it
  logic [IW-1:0]   gidx;       // index of the current owner
  logic [3:0]      burst_cnt;
  logic [15:0]     tmo_cnt;

  logic [IW-1:0]   cand;
  logic [IW-1:0]   arb_idx;
  logic            arb_found;
  logic            sel_req;
  logic [7:0]      sel_byte;
  logic [15:0]     tmo_nxt;
  logic            tmo_hit;

  // Round-robin search: candidates run from last+1 upward with wrap-around. The first asserted request wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last) + k) % N_REQ);
      if (!arb_found && bus.req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Request flag and byte of the current owner.
  always_comb begin
    sel_req  = 1'b0;
    sel_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gidx == IW'(i)) begin
        sel_req  = bus.req[i];
        sel_byte = bus.req_data[8*i +: 8];
      end
    end
  end

  // The timeout counter saturates so that a huge TIMEOUT can never wrap back into range.
  assign tmo_nxt = (tmo_cnt == 16'hFFFF) ? tmo_cnt : tmo_cnt + 16'd1;
  assign tmo_hit = ({16'd0, tmo_nxt} >= 32'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      last         <= IW'(N_REQ - 1);
      gidx         <= '0;
      burst_cnt    <= '0;
      tmo_cnt      <= '0;
      bus.grant    <= '0;
      bus.ack      <= '0;
      bus.tx_start <= 1'b0;
      bus.tx_data  <= 8'h00;
      bus.busy     <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.tx_start <= 1'b0;
      bus.ack      <= '0;
      bus.err      <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state    <= ARB;
            bus.busy <= 1'b1;
          end
        end
        ARB: begin
          if (arb_found) begin
            gidx      <= arb_idx;
            bus.grant <= N_REQ'(1) << arb_idx;
            burst_cnt <= '0;
            state     <= LOAD;
          end else begin
            // The request vanished between IDLE and ARB.
            bus.grant <= '0;
            bus.busy  <= 1'b0;
            state     <= IDLE;
          end
        end
        LOAD: begin
          if (sel_req) begin
            bus.tx_start <= 1'b1;
            bus.ack      <= bus.grant;
            bus.tx_data  <= sel_byte;
            burst_cnt    <= burst_cnt + 4'd1;
            tmo_cnt      <= '0;
            state        <= WAIT;
          end else begin
            bus.grant <= '0;
            bus.busy  <= 1'b0;
            last      <= gidx;
            state     <= IDLE;
          end
        end
        WAIT: begin
          tmo_cnt <= tmo_nxt;
          // tx_done takes precedence over a timeout that expires in the same cycle.
          if (bus.tx_done) begin
            if (sel_req && (burst_cnt < 4'(MAX_BURST))) begin
              state <= LOAD;
            end else begin
              bus.grant <= '0;
              bus.busy  <= 1'b0;
              last      <= gidx;
              state     <= IDLE;
            end
          end else if (tmo_hit) begin
            bus.err   <= 1'b1;
            bus.grant <= '0;
            bus.busy  <= 1'b0;
            last      <= gidx;
            state     <= IDLE;
          end
        end
        default: begin
          bus.grant <= '0;
          bus.busy  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. It uses two instances that share clk and rst.
// dut_a has MAX_BURST=4 and TIMEOUT=20. dut_b has MAX_BURST=1 and runs the round-robin sequence.
// Each step advances one rising edge, then waits 1 time unit. Outputs are compared and the next inputs are driven at that point.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(4)) if_a ();
  uart_tx_arbiter_if #(.N_REQ(4)) if_b ();

  uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(4), .TIMEOUT(20)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  uart_tx_arbiter #(.N_REQ(4), .MAX_BURST(1), .TIMEOUT(100)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start_a(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (if_a.tx_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_start_b(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (if_b.tx_start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Each vector holds the inputs applied before an edge and the outputs expected after that edge.
  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic        done;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        start;
    logic [7:0]  txd;
    logic        busy;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] rq, input logic [31:0] dt, input logic dn,
                              input logic [3:0] g, input logic [3:0] a, input logic st,
                              input logic [7:0] td, input logic bs);
    vec_t v;
    v.req = rq; v.data = dt; v.done = dn; v.grant = g;
    v.ack = a;  v.start = st; v.txd = td; v.busy = bs;
    return v;
  endfunction

  vec_t        vecs[17];
  logic [3:0]  rr_g[5];
  logic [7:0]  rr_d[5];

  initial begin
    bit ok;
    int starts;
    int gap;
    int k;
    bit idle_seen;
    bit regrant;
    bit err_seen;

    // Single request on requester 0, then tx_done while idle.
    vecs[0]  = mk(4'b0001, 32'hD4C3B2A5, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b1);
    vecs[1]  = mk(4'b0001, 32'hD4C3B2A5, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'h00, 1'b1);
    vecs[2]  = mk(4'b0001, 32'hD4C3B2A5, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA5, 1'b1);
    vecs[3]  = mk(4'b0000, 32'hD4C3B2A5, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'hA5, 1'b1);
    vecs[4]  = mk(4'b0000, 32'hD4C3B2A5, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b0);
    vecs[5]  = mk(4'b0000, 32'hD4C3B2A5, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b0);
    // Requester 1 withdraws its request while the block moves from ARB to LOAD.
    vecs[6]  = mk(4'b0010, 32'hD4C3B2A5, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b1);
    vecs[7]  = mk(4'b0010, 32'hD4C3B2A5, 1'b0, 4'b0010, 4'b0000, 1'b0, 8'hA5, 1'b1);
    vecs[8]  = mk(4'b0000, 32'hD4C3B2A5, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b0);
    // last is now 1, so with req=0011 requester 0 wins first.
    vecs[9]  = mk(4'b0011, 32'hD4C3B2E7, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b1);
    vecs[10] = mk(4'b0011, 32'hD4C3B2E7, 1'b0, 4'b0001, 4'b0000, 1'b0, 8'hA5, 1'b1);
    vecs[11] = mk(4'b0011, 32'hD4C3B2E7, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hE7, 1'b1);
    vecs[12] = mk(4'b0010, 32'hD4C3B2E7, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hE7, 1'b0);
    vecs[13] = mk(4'b0010, 32'hD4C3B2E7, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hE7, 1'b1);
    vecs[14] = mk(4'b0010, 32'hD4C3B2E7, 1'b0, 4'b0010, 4'b0000, 1'b0, 8'hE7, 1'b1);
    vecs[15] = mk(4'b0010, 32'hD4C3B2E7, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'hB2, 1'b1);
    vecs[16] = mk(4'b0000, 32'hD4C3B2E7, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hB2, 1'b0);

    rr_g[0] = 4'b0001; rr_g[1] = 4'b0010; rr_g[2] = 4'b0100; rr_g[3] = 4'b1000; rr_g[4] = 4'b0001;
    rr_d[0] = 8'h11;   rr_d[1] = 8'h22;   rr_d[2] = 8'h33;   rr_d[3] = 8'h44;   rr_d[4] = 8'h11;

    // ---------------- reset ----------------
    rst = 1'b1;
    if_a.req = '0; if_a.req_data = '0; if_a.tx_done = 1'b0;
    if_b.req = '0; if_b.req_data = '0; if_b.tx_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst grant",    32'(if_a.grant),    32'h0);
    check("rst ack",      32'(if_a.ack),      32'h0);
    check("rst tx_start", 32'(if_a.tx_start), 32'h0);
    check("rst tx_data",  32'(if_a.tx_data),  32'h0);
    check("rst busy",     32'(if_a.busy),     32'h0);
    check("rst err",      32'(if_a.err),      32'h0);
    check("rst b busy",   32'(if_b.busy),     32'h0);
    rst = 1'b0;

    // ---------------- round robin on dut_b (MAX_BURST=1) ----------------
    if_b.req      = 4'b1111;
    if_b.req_data = 32'h44332211;
    for (int n = 0; n < 5; n++) begin
      wait_start_b(ok);
      check($sformatf("rr%0d start seen", n), 32'(ok), 32'd1);
      check($sformatf("rr%0d grant", n), 32'(if_b.grant), 32'(rr_g[n]));
      check($sformatf("rr%0d ack", n), 32'(if_b.ack), 32'(rr_g[n]));
      check($sformatf("rr%0d tx_data", n), 32'(if_b.tx_data), 32'(rr_d[n]));
      if (n == 4) if_b.req = '0;
      repeat (10) tick();
      if_b.tx_done = 1'b1;
      tick();
      if_b.tx_done = 1'b0;
    end
    check("rr final grant", 32'(if_b.grant), 32'h0);
    check("rr final busy",  32'(if_b.busy),  32'h0);

    // ---------------- table-driven vectors on dut_a ----------------
    for (int i = 0; i < 17; i++) begin
      if_a.req      = vecs[i].req;
      if_a.req_data = vecs[i].data;
      if_a.tx_done  = vecs[i].done;
      tick();
      check($sformatf("v%0d grant", i),    32'(if_a.grant),    32'(vecs[i].grant));
      check($sformatf("v%0d ack", i),      32'(if_a.ack),      32'(vecs[i].ack));
      check($sformatf("v%0d tx_start", i), 32'(if_a.tx_start), 32'(vecs[i].start));
      check($sformatf("v%0d tx_data", i),  32'(if_a.tx_data),  32'(vecs[i].txd));
      check($sformatf("v%0d busy", i),     32'(if_a.busy),     32'(vecs[i].busy));
      check($sformatf("v%0d err", i),      32'(if_a.err),      32'h0);
    end
    if_a.tx_done = 1'b0;

    // ---------------- burst limit: requester 2 held high ----------------
    if_a.req      = 4'b0100;
    if_a.req_data = 32'h005C0000;
    starts = 0; gap = 0; idle_seen = 1'b0; regrant = 1'b0;
    for (int c = 0; c < 300 && !regrant; c++) begin
      tick();
      if_a.tx_done = 1'b0;
      if (gap > 0) begin
        gap--;
        if (gap == 0) if_a.tx_done = 1'b1;
      end
      if (if_a.tx_start && !idle_seen) begin
        starts++;
        check($sformatf("burst%0d grant", starts), 32'(if_a.grant), 32'h4);
        check($sformatf("burst%0d data", starts), 32'(if_a.tx_data), 32'h5C);
        gap = 2;
      end
      if (!idle_seen && starts > 0 && if_a.grant == 4'b0000 && !if_a.busy) begin
        idle_seen = 1'b1;
        check("burst count", 32'(starts), 32'd4);
      end else if (idle_seen && if_a.grant != 4'b0000) begin
        check("burst regrant", 32'(if_a.grant), 32'h4);
        regrant = 1'b1;
        if_a.req = '0;   // withdrawn while in LOAD, so no frame is issued
      end
    end
    check("burst regrant seen", 32'(regrant), 32'd1);
    if_a.tx_done = 1'b0;
    tick();
    check("burst withdraw start", 32'(if_a.tx_start), 32'h0);
    check("burst withdraw busy",  32'(if_a.busy),     32'h0);

    // ---------------- timeout (TIMEOUT=20) ----------------
    // last=2, so with req=0011 requester 0 is granted first.
    if_a.req      = 4'b0011;
    if_a.req_data = 32'h00002211;
    wait_start_a(ok);
    check("tmo start seen", 32'(ok), 32'd1);
    check("tmo grant",      32'(if_a.grant),   32'h1);
    check("tmo tx_data",    32'(if_a.tx_data), 32'h11);
    k = 0;
    err_seen = 1'b0;
    for (int c = 1; c <= 40 && !err_seen; c++) begin
      tick();
      k = c;
      if (if_a.err) err_seen = 1'b1;
    end
    check("tmo err seen",  32'(err_seen),   32'd1);
    check("tmo latency",   32'(k),          32'd20);
    check("tmo grant clr", 32'(if_a.grant), 32'h0);
    check("tmo busy clr",  32'(if_a.busy),  32'h0);
    tick();
    check("tmo err pulse", 32'(if_a.err),  32'h0);
    check("tmo rearb",     32'(if_a.busy), 32'h1);
    wait_start_a(ok);
    check("tmo next start", 32'(ok),           32'd1);
    check("tmo next grant", 32'(if_a.grant),   32'h2);
    check("tmo next data",  32'(if_a.tx_data), 32'h22);

    // ---------------- reset mid-WAIT while grant=0010 ----------------
    #2;
    rst = 1'b1;
    #1;
    check("arst grant",    32'(if_a.grant),    32'h0);
    check("arst ack",      32'(if_a.ack),      32'h0);
    check("arst tx_start", 32'(if_a.tx_start), 32'h0);
    check("arst tx_data",  32'(if_a.tx_data),  32'h0);
    check("arst busy",     32'(if_a.busy),     32'h0);
    check("arst err",      32'(if_a.err),      32'h0);
    tick();
    tick();
    check("arst hold err", 32'(if_a.err), 32'h0);
    rst = 1'b0;
    err_seen = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      tick();
      if (if_a.err) err_seen = 1'b1;
      if (if_a.tx_start) ok = 1'b1;
    end
    check("post-rst start seen", 32'(ok),           32'd1);
    check("post-rst grant",      32'(if_a.grant),   32'h1);
    check("post-rst tx_data",    32'(if_a.tx_data), 32'h11);
    check("post-rst no err",     32'(err_seen),     32'd0);
    if_a.req = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
